// File: rtl/associative_memory.sv
// Associative memory for hyperdimensional classification: stores one prototype
// hypervector per class and returns the nearest class by Hamming distance.
module associative_memory #(
    parameter int HV_DIMENSION = 2000,
    parameter int CLASSES      = 5,
    parameter int LABEL_WIDTH  = 3,
    parameter int MODE_WIDTH   = 1,
    parameter int DIST_WIDTH   = $clog2(HV_DIMENSION + 1)
) (
    input  logic                   Clk_CI,
    input  logic                   Reset_RBI,
    input  logic                   ValidIn_SI,
    output logic                   ReadyOut_SO,
    input  logic [MODE_WIDTH-1:0]  ModeIn_SI,
    input  logic [LABEL_WIDTH-1:0] LabelIn_DI,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    output logic                   ValidOut_SO,
    input  logic                   ReadyIn_SI,
    output logic [LABEL_WIDTH-1:0] LabelOut_DO,
    output logic [DIST_WIDTH-1:0]  DistanceOut_DO
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SEARCH, S_OUTPUT} state_t;

    state_t r_state, w_state_next;

    logic [LABEL_WIDTH-1:0]  r_label;
    logic [HV_DIMENSION-1:0] r_query;
    logic [HV_DIMENSION-1:0] r_proto [CLASSES];
    logic [LABEL_WIDTH-1:0]  r_cnt;
    logic [DIST_WIDTH-1:0]   r_best_dist;
    logic [LABEL_WIDTH-1:0]  r_best_label;
    logic [LABEL_WIDTH-1:0]  r_label_out;
    logic [DIST_WIDTH-1:0]   r_dist_out;

    logic [HV_DIMENSION-1:0] w_proto;
    logic [HV_DIMENSION-1:0] w_xor;
    logic [DIST_WIDTH-1:0]   w_dist;
    logic                    w_better;
    logic                    w_last;

    assign w_last   = (r_cnt == LABEL_WIDTH'(CLASSES - 1));
    assign w_xor    = r_query ^ w_proto;
    assign w_better = (w_dist < r_best_dist);

    // Prototype read mux selected by the search counter.
    always_comb begin
        w_proto = '0;
        for (int c = 0; c < CLASSES; c++) begin
            if (int'(r_cnt) == c) w_proto = r_proto[c];
        end
    end

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < HV_DIMENSION; i++) begin
            w_dist = w_dist + DIST_WIDTH'(w_xor[i]);
        end
    end

    // FSM: state register
    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (ValidIn_SI)
                    w_state_next = (ModeIn_SI == MODE_WIDTH'(1)) ? S_WRITE : S_SEARCH;
            end
            S_WRITE:  w_state_next = S_IDLE;
            S_SEARCH: if (w_last) w_state_next = S_OUTPUT;
            S_OUTPUT: if (ReadyIn_SI) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ReadyOut_SO = (r_state == S_IDLE);
        ValidOut_SO = (r_state == S_OUTPUT);
    end

    assign LabelOut_DO    = r_label_out;
    assign DistanceOut_DO = r_dist_out;

    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            r_label      <= '0;
            r_query      <= '0;
            r_cnt        <= '0;
            r_best_dist  <= '1;
            r_best_label <= '0;
            r_label_out  <= '0;
            r_dist_out   <= '1;
            for (int c = 0; c < CLASSES; c++) r_proto[c] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ValidIn_SI) begin
                        r_label      <= LabelIn_DI;
                        r_query      <= HypervectorIn_DI;
                        r_cnt        <= '0;
                        r_best_dist  <= '1;
                        r_best_label <= '0;
                    end
                end
                S_WRITE: begin
                    // Labels >= CLASSES match no entry, so the write is dropped.
                    for (int c = 0; c < CLASSES; c++) begin
                        if (int'(r_label) == c) r_proto[c] <= r_query;
                    end
                end
                S_SEARCH: begin
                    if (w_better) begin
                        r_best_dist  <= w_dist;
                        r_best_label <= r_cnt;
                    end
                    if (w_last) begin
                        r_label_out <= w_better ? r_cnt  : r_best_label;
                        r_dist_out  <= w_better ? w_dist : r_best_dist;
                    end else begin
                        r_cnt <= r_cnt + LABEL_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_associative_memory.sv
// Directed self-checking bench for associative_memory at default parameters.
module tb_associative_memory;

    localparam int HV = 2000;

    logic            clk = 1'b0;
    logic            Reset_RBI;
    logic            ValidIn_SI;
    logic            ReadyOut_SO;
    logic [0:0]      ModeIn_SI;
    logic [2:0]      LabelIn_DI;
    logic [HV-1:0]   HypervectorIn_DI;
    logic            ValidOut_SO;
    logic            ReadyIn_SI;
    logic [2:0]      LabelOut_DO;
    logic [10:0]     DistanceOut_DO;

    int total  = 0;
    int passed = 0;

    logic [HV-1:0] P;
    logic [HV-1:0] ONES;

    always #5 clk = ~clk;

    associative_memory dut (
        .Clk_CI          (clk),
        .Reset_RBI       (Reset_RBI),
        .ValidIn_SI      (ValidIn_SI),
        .ReadyOut_SO     (ReadyOut_SO),
        .ModeIn_SI       (ModeIn_SI),
        .LabelIn_DI      (LabelIn_DI),
        .HypervectorIn_DI(HypervectorIn_DI),
        .ValidOut_SO     (ValidOut_SO),
        .ReadyIn_SI      (ReadyIn_SI),
        .LabelOut_DO     (LabelOut_DO),
        .DistanceOut_DO  (DistanceOut_DO)
    );

    task automatic do_reset();
        Reset_RBI  = 1'b0;
        ValidIn_SI = 1'b0;
        repeat (2) @(negedge clk);
        Reset_RBI = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic send(input logic mode, input logic [2:0] lbl, input logic [HV-1:0] hv);
        ValidIn_SI       = 1'b1;
        ModeIn_SI        = mode;
        LabelIn_DI       = lbl;
        HypervectorIn_DI = hv;
        @(negedge clk);
        ValidIn_SI = 1'b0;
    endtask

    task automatic train(input logic [2:0] lbl, input logic [HV-1:0] hv);
        send(1'b1, lbl, hv);
        @(negedge clk);
    endtask

    // Cycle index (accept cycle = 0) at which ValidOut_SO is first seen; 0 on timeout.
    task automatic wait_valid(output int cyc);
        cyc = 0;
        for (int k = 1; k <= 20 && cyc == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (ValidOut_SO) cyc = k;
        end
    endtask

    task automatic test_reset();
        ValidIn_SI = 1'b0; ModeIn_SI = '0; LabelIn_DI = '0;
        HypervectorIn_DI = '0; ReadyIn_SI = 1'b0;
        do_reset();
        total++; if (ReadyOut_SO !== 1'b1) $display("FAIL reset_ready: got %0b expected 1", ReadyOut_SO); else passed++;
        total++; if (ValidOut_SO !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", ValidOut_SO); else passed++;
        total++; if (LabelOut_DO !== 3'd0) $display("FAIL reset_label: got %0d expected 0", LabelOut_DO); else passed++;
        total++; if (DistanceOut_DO !== 11'd2047) $display("FAIL reset_dist: got %0d expected 2047", DistanceOut_DO); else passed++;
    endtask

    task automatic test_exact_match();
        int c;
        do_reset();
        train(3'd2, P);
        ReadyIn_SI = 1'b1;
        send(1'b0, 3'd0, P);
        wait_valid(c);
        total++; if (c !== 6) $display("FAIL exact_latency: got %0d expected 6", c); else passed++;
        total++; if (LabelOut_DO !== 3'd2) $display("FAIL exact_label: got %0d expected 2", LabelOut_DO); else passed++;
        total++; if (DistanceOut_DO !== 11'd0) $display("FAIL exact_dist: got %0d expected 0", DistanceOut_DO); else passed++;
        @(negedge clk);
        total++; if ({ReadyOut_SO, ValidOut_SO} !== 2'b10)
            $display("FAIL exact_next_idle: got ready=%0b valid=%0b expected ready=1 valid=0", ReadyOut_SO, ValidOut_SO);
        else passed++;
        total++; if ({LabelOut_DO, DistanceOut_DO} !== {3'd2, 11'd0})
            $display("FAIL exact_retain: got label=%0d dist=%0d expected label=2 dist=0", LabelOut_DO, DistanceOut_DO);
        else passed++;
    endtask

    task automatic test_tie_break();
        int c;
        logic [HV-1:0] m;
        m = '0; m[9:0] = '1;
        do_reset();
        train(3'd1, P);
        train(3'd3, P);
        ReadyIn_SI = 1'b1;
        send(1'b0, 3'd0, P ^ m);
        wait_valid(c);
        total++; if (c === 0) $display("FAIL tie_valid: got timeout expected valid"); else passed++;
        total++; if (LabelOut_DO !== 3'd1) $display("FAIL tie_label: got %0d expected 1", LabelOut_DO); else passed++;
        total++; if (DistanceOut_DO !== 11'd10) $display("FAIL tie_dist: got %0d expected 10", DistanceOut_DO); else passed++;
        @(negedge clk);
    endtask

    // Relies on classes 1 and 3 holding P from the tie-break test.
    task automatic test_backpressure();
        int c;
        logic [HV-1:0] m;
        m = '0; m[3:0] = '1;
        ReadyIn_SI = 1'b0;
        send(1'b0, 3'd0, P ^ m);
        wait_valid(c);
        total++; if (c !== 6) $display("FAIL bp_latency: got %0d expected 6", c); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++;
            if ({ValidOut_SO, ReadyOut_SO, LabelOut_DO, DistanceOut_DO} !== {1'b1, 1'b0, 3'd1, 11'd4})
                $display("FAIL bp_hold%0d: got valid=%0b ready=%0b label=%0d dist=%0d expected valid=1 ready=0 label=1 dist=4",
                         i, ValidOut_SO, ReadyOut_SO, LabelOut_DO, DistanceOut_DO);
            else passed++;
            @(negedge clk);
        end
        ReadyIn_SI = 1'b1;
        total++; if ({ValidOut_SO, ReadyOut_SO} !== 2'b10)
            $display("FAIL bp_last_hold: got valid=%0b ready=%0b expected valid=1 ready=0", ValidOut_SO, ReadyOut_SO);
        else passed++;
        @(negedge clk);
        total++; if ({ValidOut_SO, ReadyOut_SO} !== 2'b01)
            $display("FAIL bp_release: got valid=%0b ready=%0b expected valid=0 ready=1", ValidOut_SO, ReadyOut_SO);
        else passed++;
    endtask

    task automatic test_out_of_range();
        int c;
        do_reset();
        ReadyIn_SI = 1'b1;
        send(1'b1, 3'd6, ONES);
        total++; if ({ValidOut_SO, ReadyOut_SO} !== 2'b00)
            $display("FAIL oor_write_state: got valid=%0b ready=%0b expected valid=0 ready=0", ValidOut_SO, ReadyOut_SO);
        else passed++;
        @(negedge clk);
        total++; if ({ValidOut_SO, ReadyOut_SO} !== 2'b01)
            $display("FAIL oor_back_idle: got valid=%0b ready=%0b expected valid=0 ready=1", ValidOut_SO, ReadyOut_SO);
        else passed++;
        send(1'b0, 3'd0, ONES);
        wait_valid(c);
        total++; if (c === 0) $display("FAIL oor_valid: got timeout expected valid"); else passed++;
        total++; if (DistanceOut_DO !== 11'd2000) $display("FAIL oor_dist: got %0d expected 2000", DistanceOut_DO); else passed++;
        total++; if (LabelOut_DO !== 3'd0) $display("FAIL oor_label: got %0d expected 0", LabelOut_DO); else passed++;
        @(negedge clk);
    endtask

    task automatic test_mid_search_reset();
        int  c;
        logic seen;
        do_reset();
        train(3'd0, ONES);
        ReadyIn_SI = 1'b1;
        send(1'b0, 3'd0, ONES);
        @(negedge clk);
        @(negedge clk);
        Reset_RBI = 1'b0;
        @(negedge clk);
        Reset_RBI = 1'b1;
        total++;
        if ({ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO} !== {1'b1, 1'b0, 3'd0, 11'd2047})
            $display("FAIL msr_state: got ready=%0b valid=%0b label=%0d dist=%0d expected ready=1 valid=0 label=0 dist=2047",
                     ReadyOut_SO, ValidOut_SO, LabelOut_DO, DistanceOut_DO);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ValidOut_SO) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL msr_no_valid: got valid seen=%0b expected 0", seen); else passed++;
        send(1'b0, 3'd0, ONES);
        wait_valid(c);
        total++; if (c === 0) $display("FAIL msr_valid: got timeout expected valid"); else passed++;
        total++; if (DistanceOut_DO !== 11'd2000) $display("FAIL msr_dist: got %0d expected 2000", DistanceOut_DO); else passed++;
        total++; if (LabelOut_DO !== 3'd0) $display("FAIL msr_label: got %0d expected 0", LabelOut_DO); else passed++;
        @(negedge clk);
    endtask

    initial begin
        P    = {1000{2'b10}};
        ONES = '1;
        Reset_RBI = 1'b0;
        test_reset();
        test_exact_match();
        test_tie_break();
        test_backpressure();
        test_out_of_range();
        test_mid_search_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
